// File: rtl/mul_sequencer.sv
// Shift-add multiply sequencer: latches operands on a decode MUL start, iterates one multiplier
// bit per cycle while stalling the pipeline, and holds the product until writeback accepts it.
module mul_sequencer #(
   parameter int WIDTH      = 32,
   parameter bit EARLY_EXIT = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic [3:0]       dest_in,
   input  logic             abort,
   input  logic             result_ready,
   output logic             busy,
   output logic             stall,
   output logic             result_valid,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi,
   output logic [3:0]       dest_out,
   output logic             overflow
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t             state;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic [CW-1:0]      count;

   logic [2*WIDTH-1:0] acc_next;
   logic [WIDTH-1:0]   mplier_next;
   logic               last_step;

   always_comb begin
      acc_next    = mplier[0] ? (acc + mcand) : acc;
      mplier_next = mplier >> 1;
      // Early exit looks at the multiplier after this step's shift, so a zero op_b still takes one step.
      last_step   = (count == CW'(WIDTH - 1)) || (EARLY_EXIT && (mplier_next == '0));
   end

   assign busy         = (state != IDLE);
   assign stall        = (state != IDLE);
   assign result_valid = (state == DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         acc       <= '0;
         mcand     <= '0;
         mplier    <= '0;
         count     <= '0;
         result_lo <= '0;
         result_hi <= '0;
         dest_out  <= '0;
         overflow  <= 1'b0;
      end else if (abort) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  mcand    <= {{WIDTH{1'b0}}, op_a};
                  mplier   <= op_b;
                  acc      <= '0;
                  count    <= '0;
                  dest_out <= dest_in;
                  state    <= BUSY;
               end
            end
            BUSY: begin
               acc    <= acc_next;
               mcand  <= mcand << 1;
               mplier <= mplier_next;
               count  <= count + CW'(1);
               if (last_step) begin
                  result_lo <= acc_next[WIDTH-1:0];
                  result_hi <= acc_next[2*WIDTH-1:WIDTH];
                  overflow  <= |acc_next[2*WIDTH-1:WIDTH];
                  state     <= DONE;
               end
            end
            DONE: begin
               if (result_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench: two sequencers (early exit on/off) share stimulus; table vectors plus corner sequences.
module tb_mul_sequencer;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic [3:0]  dest_in = '0;
   logic        abort = 1'b0;
   logic        result_ready = 1'b1;

   logic        e_busy, e_stall, e_valid, e_ov;
   logic [31:0] e_lo, e_hi;
   logic [3:0]  e_dest;
   logic        f_busy, f_stall, f_valid, f_ov;
   logic [31:0] f_lo, f_hi;
   logic [3:0]  f_dest;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   mul_sequencer #(.WIDTH(32), .EARLY_EXIT(1'b1)) u_ee (
      .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b), .dest_in(dest_in),
      .abort(abort), .result_ready(result_ready), .busy(e_busy), .stall(e_stall),
      .result_valid(e_valid), .result_lo(e_lo), .result_hi(e_hi), .dest_out(e_dest),
      .overflow(e_ov));

   mul_sequencer #(.WIDTH(32), .EARLY_EXIT(1'b0)) u_full (
      .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b), .dest_in(dest_in),
      .abort(abort), .result_ready(result_ready), .busy(f_busy), .stall(f_stall),
      .result_valid(f_valid), .result_lo(f_lo), .result_hi(f_hi), .dest_out(f_dest),
      .overflow(f_ov));

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  dest;
      logic [31:0] lo;
      logic [31:0] hi;
      logic        ov;
      int          s_ee;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Starts an op at the current negedge with result_ready=1 and checks both instances.
   task automatic run_check(input vec_t v);
      int s_e, s_f;
      logic [31:0] lo_e, hi_e, lo_f, hi_f;
      logic ov_e, ov_f;
      logic [3:0] d_e, d_f;
      s_e = 0; s_f = 0;
      lo_e = '0; hi_e = '0; lo_f = '0; hi_f = '0; ov_e = 0; ov_f = 0; d_e = '0; d_f = '0;
      op_a = v.a; op_b = v.b; dest_in = v.dest; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 1; i <= 36; i++) begin
         @(negedge clk);
         if (s_e == 0 && e_valid) begin
            s_e = i; lo_e = e_lo; hi_e = e_hi; ov_e = e_ov; d_e = e_dest;
         end else if (s_e != 0 && i == s_e + 1) begin
            chk("ee_valid_pulse", {63'd0, e_valid}, 64'd0);
            chk("ee_busy_after", {63'd0, e_busy}, 64'd0);
         end
         if (s_f == 0 && f_valid) begin
            s_f = i; lo_f = f_lo; hi_f = f_hi; ov_f = f_ov; d_f = f_dest;
         end else if (s_f != 0 && i == s_f + 1) begin
            chk("full_valid_pulse", {63'd0, f_valid}, 64'd0);
         end
      end
      chk("ee_latency", 64'(s_e), 64'(v.s_ee));
      chk("ee_lo", {32'd0, lo_e}, {32'd0, v.lo});
      chk("ee_hi", {32'd0, hi_e}, {32'd0, v.hi});
      chk("ee_ov", {63'd0, ov_e}, {63'd0, v.ov});
      chk("ee_dest", {60'd0, d_e}, {60'd0, v.dest});
      chk("full_latency", 64'(s_f), 64'd32);
      chk("full_lo", {32'd0, lo_f}, {32'd0, v.lo});
      chk("full_hi", {32'd0, hi_f}, {32'd0, v.hi});
      chk("full_ov", {63'd0, ov_f}, {63'd0, v.ov});
   endtask

   initial begin
      vecs[0] = '{32'd3,        32'd5,        4'd7,  32'd15,       32'd0,        1'b0, 3};
      vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 4'd1,  32'h00000001, 32'hFFFFFFFE, 1'b1, 32};
      vecs[2] = '{32'h1234,     32'd0,        4'd2,  32'd0,        32'd0,        1'b0, 1};
      vecs[3] = '{32'h12345678, 32'd1,        4'd3,  32'h12345678, 32'd0,        1'b0, 1};
      vecs[4] = '{32'h00010000, 32'h00010000, 4'd4,  32'd0,        32'd1,        1'b1, 17};
      vecs[5] = '{32'hFFFFFFFD, 32'd7,        4'd9,  32'hFFFFFFEB, 32'd6,        1'b1, 3};
      vecs[6] = '{32'h80000000, 32'h80000000, 4'd15, 32'd0,        32'h40000000, 1'b1, 32};
      vecs[7] = '{32'd100,      32'd200,      4'd6,  32'd20000,    32'd0,        1'b0, 8};

      // Reset state
      @(negedge clk);
      chk("rst_busy", {63'd0, e_busy}, 64'd0);
      chk("rst_stall", {63'd0, e_stall}, 64'd0);
      chk("rst_valid", {63'd0, e_valid}, 64'd0);
      chk("rst_result", {e_hi, e_lo}, 64'd0);
      chk("rst_dest_ov", {59'd0, e_dest, e_ov}, 64'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int k = 0; k < 8; k++) run_check(vecs[k]);

      // Result held while writeback stalls; starts in DONE are ignored.
      result_ready = 1'b0;
      op_a = 32'd9; op_b = 32'd3; dest_in = 4'd5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (34) @(negedge clk);
      chk("hold_ee_valid", {63'd0, e_valid}, 64'd1);
      chk("hold_full_valid", {63'd0, f_valid}, 64'd1);
      for (int k = 0; k < 5; k++) begin
         op_a = 32'(50 + k); op_b = 32'(k + 1); dest_in = 4'(k); start = 1'b1;
         @(negedge clk);
         chk("hold_valid", {63'd0, e_valid}, 64'd1);
         chk("hold_stall", {63'd0, e_stall}, 64'd1);
         chk("hold_lo", {32'd0, e_lo}, 64'd27);
         chk("hold_dest", {60'd0, e_dest}, 64'd5);
         chk("hold_full_lo", {32'd0, f_lo}, 64'd27);
      end
      start = 1'b0;
      result_ready = 1'b1;
      @(negedge clk);
      chk("hs_ee_busy", {63'd0, e_busy}, 64'd0);
      chk("hs_full_busy", {63'd0, f_busy}, 64'd0);
      repeat (3) @(negedge clk);
      chk("no_queued_ee", {63'd0, e_busy}, 64'd0);
      chk("no_queued_full", {63'd0, f_busy}, 64'd0);

      // Abort at step 10 of a 32-step op, then restart one cycle later.
      op_a = 32'hFFFFFFFF; op_b = 32'hFFFFFFFF; dest_in = 4'd8; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 1; i <= 9; i++) begin
         @(negedge clk);
         if (i == 9) abort = 1'b1;
      end
      @(negedge clk);
      abort = 1'b0;
      chk("abort_busy", {63'd0, f_busy}, 64'd0);
      chk("abort_valid", {63'd0, f_valid}, 64'd0);
      run_check(vecs[5]);

      // Abort beats start in IDLE.
      op_a = 32'd4; op_b = 32'd4; start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      chk("abort_vs_start", {63'd0, e_busy}, 64'd0);
      @(negedge clk);

      // Asynchronous reset mid-BUSY, asserted between clock edges.
      op_a = 32'hFFFFFFFF; op_b = 32'hFFFFFFFF; dest_in = 4'd11; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", {62'd0, e_busy, f_busy}, 64'd0);
      chk("arst_stall", {62'd0, e_stall, f_stall}, 64'd0);
      chk("arst_valid", {62'd0, e_valid, f_valid}, 64'd0);
      chk("arst_result", {e_hi, e_lo}, 64'd0);
      chk("arst_dest", {60'd0, e_dest}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_check(vecs[7]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
